// File: rtl/dmem_dma_engine.sv
// Block-copy / block-fill bus initiator for the data-memory port.
// Copy moves one word per READ+WRITE pair; fill writes one word per WRITE cycle.
module dmem_dma_engine #(
  parameter int LEN_W = 6
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_value,
  input  logic             grant,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic [31:0]      fill_q, fill_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (start) begin
          // Source alignment only matters when the source is actually read.
          if (len == '0) begin
            state_d = S_FIN;
          end else if ((!mode && src_addr[1:0] != 2'b00) || dst_addr[1:0] != 2'b00) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            mode_d  = mode;
            fill_d  = fill_value;
            state_d = mode ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        if (grant) begin
          buf_d   = mem_rdata;
          src_d   = src_q + 32'd4;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (grant) begin
          dst_d = dst_q + 32'd4;
          rem_d = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
          if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) state_d = S_FIN;
          else                                     state_d = mode_q ? S_WRITE : S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state_q == S_READ)  mem_addr = src_q;
    if (state_q == S_WRITE) begin
      mem_addr  = dst_q;
      mem_wdata = mode_q ? fill_q : buf_q;
    end
  end

  assign mem_we = (state_q == S_WRITE) && grant;
  assign busy   = (state_q == S_READ) || (state_q == S_WRITE);
  assign done   = (state_q == S_FIN);
  assign err    = (state_q == S_FIN) && err_q;

endmodule

// File: tb/tb_dmem_dma_engine.sv
// Directed bench for dmem_dma_engine: word-array memory model, write log and
// cycle counting from the start edge to the done cycle.
module tb_dmem_dma_engine;

  logic        clock = 1'b0;
  logic        clrn, start, mode, grant;
  logic [31:0] src_addr, dst_addr, fill_value, mem_rdata;
  logic [5:0]  len;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, busy, done, err;

  logic [31:0] mem [0:255];
  logic [31:0] waddr_log [$];
  int          we_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  dmem_dma_engine #(.LEN_W(6)) dut (
    .clock(clock), .clrn(clrn), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
    .grant(grant), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .busy(busy), .done(done), .err(err)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      waddr_log.push_back(mem_addr);
      we_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Runs one transfer with grant=1 except for an optional stall window.
  // cyc counts negedges after the start edge until done is seen.
  task automatic xfer(input logic md, input logic [31:0] s, input logic [31:0] d,
                      input logic [5:0] n, input logic [31:0] fv,
                      input int stall_at, input int stall_n, input int restart_at,
                      output int cyc, output logic e, output int nwe, output int stall_we);
    int base;
    @(negedge clock);
    mode = md; src_addr = s; dst_addr = d; len = n; fill_value = fv;
    start = 1'b1; grant = 1'b1;
    base = we_cnt; cyc = 0; e = 1'b0; stall_we = 0;
    while (cyc < 200) begin
      @(negedge clock);
      cyc++;
      // Scramble the request fields: they must have been latched already.
      src_addr = 32'h3; dst_addr = 32'h300; len = 6'd1; mode = 1'b1; fill_value = 32'hBAD0BAD0;
      start = (cyc == restart_at);
      grant = !(cyc >= stall_at && cyc < stall_at + stall_n);
      #1;
      if (!grant && mem_we) stall_we++;
      if (done) begin e = err; break; end
    end
    start = 1'b0; grant = 1'b1;
    nwe = we_cnt - base;
  endtask

  int          cyc, nwe, swe, nlog;
  logic        e;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    clrn = 1'b0; start = 1'b1; mode = 1'b0; grant = 1'b1;
    src_addr = 32'h0; dst_addr = 32'h40; len = 6'd4; fill_value = 32'h0;

    // Reset held with start asserted
    repeat (2) @(negedge clock);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_flags", {28'd0, mem_we, busy, done, err}, 32'h0);
    @(negedge clock);
    chk("rst_start_busy", {31'd0, busy}, 32'h0);
    clrn = 1'b1; start = 1'b0;
    @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 32'h0);

    // Copy 4 words 0x00 -> 0x40
    xfer(1'b0, 32'h00, 32'h40, 6'd4, 32'h0, 0, 0, 0, cyc, e, nwe, swe);
    chk("copy_cycles", cyc, 9);
    chk("copy_err", {31'd0, e}, 32'h0);
    chk("copy_we", nwe, 4);
    chk("copy_w0", mem[16], 32'h11);
    chk("copy_w1", mem[17], 32'h22);
    chk("copy_w2", mem[18], 32'h33);
    chk("copy_w3", mem[19], 32'h44);
    @(negedge clock);
    chk("done_one_cycle", {30'd0, done, busy}, 32'h0);

    // Fill 3 words into I/O space
    xfer(1'b1, 32'h0, 32'h80, 6'd3, 32'hA5A5A5A5, 0, 0, 0, cyc, e, nwe, swe);
    chk("fill_cycles", cyc, 4);
    chk("fill_we", nwe, 3);
    chk("fill_p0", mem[32], 32'hA5A5A5A5);
    chk("fill_p1", mem[33], 32'hA5A5A5A5);
    chk("fill_p2", mem[34], 32'hA5A5A5A5);

    // Copy len=2 with grant low for 3 cycles in the first WRITE (cycle 2)
    xfer(1'b0, 32'h00, 32'h100, 6'd2, 32'h0, 2, 3, 0, cyc, e, nwe, swe);
    chk("stall_cycles", cyc, 8);
    chk("stall_we_during", swe, 0);
    chk("stall_we", nwe, 2);
    chk("stall_w0", mem[64], 32'h11);
    chk("stall_w1", mem[65], 32'h22);

    // Forward overlap propagates the first word
    xfer(1'b0, 32'h40, 32'h44, 6'd2, 32'h0, 0, 0, 0, cyc, e, nwe, swe);
    chk("ovl_cycles", cyc, 5);
    chk("ovl_w1", mem[17], 32'h11);
    chk("ovl_w2", mem[18], 32'h11);

    // len=0
    xfer(1'b0, 32'h0, 32'h40, 6'd0, 32'h0, 0, 0, 0, cyc, e, nwe, swe);
    chk("len0_cycles", cyc, 1);
    chk("len0_err", {31'd0, e}, 32'h0);
    chk("len0_we", nwe, 0);

    // Misaligned destination
    xfer(1'b0, 32'h0, 32'h42, 6'd2, 32'h0, 0, 0, 0, cyc, e, nwe, swe);
    chk("mis_dst_cycles", cyc, 1);
    chk("mis_dst_err", {31'd0, e}, 32'h1);
    chk("mis_dst_we", nwe, 0);

    // Misaligned source: error in copy, ignored in fill
    xfer(1'b0, 32'h1, 32'h40, 6'd2, 32'h0, 0, 0, 0, cyc, e, nwe, swe);
    chk("mis_src_copy_err", {31'd0, e}, 32'h1);
    chk("mis_src_copy_we", nwe, 0);
    xfer(1'b1, 32'h1, 32'h140, 6'd1, 32'h5A5A0001, 0, 0, 0, cyc, e, nwe, swe);
    chk("mis_src_fill_err", {31'd0, e}, 32'h0);
    chk("mis_src_fill_data", mem[80], 32'h5A5A0001);

    // Start pulse while busy is ignored
    xfer(1'b0, 32'h00, 32'h200, 6'd3, 32'h0, 0, 0, 3, cyc, e, nwe, swe);
    chk("busy_start_cycles", cyc, 7);
    chk("busy_start_we", nwe, 3);
    chk("busy_start_w2", mem[130], 32'h33);
    chk("busy_start_untouched", mem[192], 32'h0);

    // Address wrap
    nlog = waddr_log.size();
    xfer(1'b1, 32'h0, 32'hFFFFFFFC, 6'd2, 32'hDEADBEEF, 0, 0, 0, cyc, e, nwe, swe);
    chk("wrap_we", nwe, 2);
    chk("wrap_a0", waddr_log[nlog], 32'hFFFFFFFC);
    chk("wrap_a1", waddr_log[nlog+1], 32'h00000000);

    // Reset mid-copy
    nlog = we_cnt;
    @(negedge clock);
    mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h280; len = 6'd4; start = 1'b1; grant = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); clrn = 1'b0;
    #1;
    chk("abort_pre_busy", {31'd0, busy}, 32'h1);
    @(negedge clock);
    chk("abort_flags", {28'd0, mem_we, busy, done, err}, 32'h0);
    clrn = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done || busy) cyc++;
    end
    chk("abort_no_done", cyc, 0);
    chk("abort_writes", we_cnt - nlog, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_dma_engine.md
Name: dmem_dma_engine

Overview:
- Bus initiator that drives the data-memory port (address, write data, write enable, read data) of the single-cycle computer's memory/IO subsystem.
- Performs block copy (memory→memory or memory→IO) and block fill, word by word.
- Sits beside the CPU on the data-memory bus. An external mux hands it the bus when grant=1.
- Provides program/debug loading and memory-mapped I/O burst output without CPU instructions.

Parameters:
- LEN_W, 6, width of the word-count field (max 63 words per transfer).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  synchronous active-low reset, sampled on rising edge of clock.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0=copy (read src, write dst), 1=fill (write fill_value to dst).
- src_addr  in  32  byte address of first source word.
- dst_addr  in  32  byte address of first destination word.
- len  in  LEN_W  number of words to transfer.
- fill_value  in  32  word written in fill mode.
- grant  in  1  bus granted to this block; 0 stalls the engine.
- mem_rdata  in  32  read data returned by data memory / IO input mux for current mem_addr.
- mem_addr  out  32  byte address driven to data memory.
- mem_wdata  out  32  write data.
- mem_we  out  1  write enable (memory gates it with its own write clock phase).
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.

Behaviour:
- Reset (clrn=0 at edge): state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, err=0; internal counters and buffer cleared. Reset mid-transfer aborts immediately; no further writes; no done pulse.
- States: IDLE, READ, WRITE, FIN.
- IDLE:
  - start=1 with len=0 → FIN with err=0; no bus access.
  - start=1 with src_addr[1:0]≠0 (copy mode only) or dst_addr[1:0]≠0 → FIN with err=1; no bus access.
  - Otherwise latch src, dst, len, mode, fill_value into internal registers. Next state is READ (copy) or WRITE (fill). busy=1 from the next cycle.
- READ: mem_addr=src reg, mem_we=0.
  - grant=1: capture mem_rdata into buffer at the edge; src+=4; go to WRITE.
  - grant=0: hold state; no capture.
- WRITE: mem_addr=dst reg, mem_wdata=buffer (copy) or fill_value (fill), mem_we=grant.
  - grant=1: at the edge dst+=4, remaining-=1.
    - remaining reaches 0 → FIN.
    - Otherwise → READ (copy) or stay in WRITE (fill).
  - grant=0: hold state, mem_we=0.
- FIN: busy=0, done=1 (err as decided in IDLE) for exactly one cycle, then IDLE.
- mem_we is never 1 outside WRITE or while grant=0.
- Address arithmetic: 32-bit, increments of 4, wraps modulo 2^32. Addresses with bit 7 set target the I/O space and are treated identically (write to output ports / read input ports).
- Latency with grant held at 1, from the start edge to the done cycle:
  - copy: 2·len+1 cycles.
  - fill: len+1 cycles.
- start while busy or in FIN is ignored.
- Input fields are only sampled at start acceptance; later changes have no effect.
- Overlapping src/dst is copied in ascending order, word by word. Forward overlap (dst>src) therefore propagates data, and this is the defined behaviour.

Test Plan:
- Reset then idle: clrn=0 for 2 cycles → all outputs 0; start=1 with clrn=0 → no state change, busy stays 0.
- Copy 4 words, src=0x00, dst=0x40, grant=1, memory preloaded 0x11,0x22,0x33,0x44 → writes at 0x40..0x4C with the same data; done after exactly 9 cycles; exactly 4 mem_we pulses.
- Fill 3 words, dst=0x80 (I/O space), fill_value=0xA5A5A5A5 → out_port0..2 all 0xA5A5A5A5; done after 4 cycles.
- Stall: copy len=2 with grant dropped for 3 cycles during the first WRITE → mem_we=0 during the stall; data correct; done delayed by exactly 3 cycles (8 cycles total).
- Errors and corners:
  - len=0 → done 1 cycle after start, err=0, no accesses.
  - dst_addr=0x42 → done and err together, no accesses.
  - start while busy → ignored.
- Wrap and abort:
  - fill len=2, dst=0xFFFFFFFC → writes at 0xFFFFFFFC then 0x00000000.
  - clrn=0 mid copy → mem_we=0 next cycle, state IDLE, no done.
